// File: rtl/traffic_light_monitor.sv
// Passive R/G/Y lamp monitor: phase-length reporting and G->Y->R->G sequence checking.
// Optional phase timeout checker enabled by defining TL_MON_TIMEOUT_EN.
module traffic_light_monitor #(
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] MAX_PHASE = CNT_W'(1000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             R,
  input  logic             G,
  input  logic             Y,
  output logic             phase_vld,
  output logic [1:0]       phase_id,
  output logic [CNT_W-1:0] phase_len,
  output logic             err_seq,
  output logic             err_onehot,
  output logic [7:0]       err_cnt
`ifdef TL_MON_TIMEOUT_EN
  ,
  output logic             err_timeout
`endif
);

  typedef enum logic [1:0] {
    PhNone = 2'd0,
    PhG    = 2'd1,
    PhY    = 2'd2,
    PhR    = 2'd3
  } phase_t;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [2:0]       smp;    // {R, G, Y}
  logic [2:0]       smp_d;
  phase_t           cur;
  phase_t           new_ph;
  logic [CNT_W-1:0] cnt;

  logic cnt_max;
  logic multi_hot;
  logic legal;
  logic seq_ev;
  logic oh_ev;
  logic to_ev;
  logic any_ev;

  always_comb begin
    new_ph = PhNone;
    case (smp)
      3'b010:  new_ph = PhG;
      3'b001:  new_ph = PhY;
      3'b100:  new_ph = PhR;
      default: new_ph = PhNone;
    endcase
  end

  always_comb begin
    cnt_max   = &cnt;
    multi_hot = ($countones(smp) >= 2);
    legal     = ((cur == PhG) && (new_ph == PhY)) ||
                ((cur == PhY) && (new_ph == PhR)) ||
                ((cur == PhR) && (new_ph == PhG));
    // Only valid->valid changes are judged; NONE on either side is a resync or a gap.
    seq_ev    = (cur != PhNone) && (new_ph != PhNone) && (new_ph != cur) && !legal;
    oh_ev     = multi_hot && (smp != smp_d);
`ifdef TL_MON_TIMEOUT_EN
    to_ev     = (cur != PhNone) && (new_ph == cur) && !cnt_max &&
                ((cnt + CntOne) == MAX_PHASE);
`else
    to_ev     = 1'b0;
`endif
    any_ev    = seq_ev || oh_ev || to_ev;
  end

`ifndef TL_MON_TIMEOUT_EN
  logic unused_max_phase;
  assign unused_max_phase = ^MAX_PHASE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      smp        <= 3'b000;
      smp_d      <= 3'b000;
      cur        <= PhNone;
      cnt        <= '0;
      phase_vld  <= 1'b0;
      phase_id   <= 2'd0;
      phase_len  <= '0;
      err_seq    <= 1'b0;
      err_onehot <= 1'b0;
      err_cnt    <= 8'd0;
`ifdef TL_MON_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
    end else begin
      smp       <= {R, G, Y};
      smp_d     <= smp;
      phase_vld <= 1'b0;

      if (new_ph == cur) begin
        if (!cnt_max) begin
          cnt <= cnt + CntOne;
        end
      end else begin
        cur <= new_ph;
        cnt <= CntOne;
        if (cur != PhNone) begin
          phase_vld <= 1'b1;
          phase_id  <= cur;
          phase_len <= cnt;
        end
      end

      if (seq_ev) begin
        err_seq <= 1'b1;
      end
      if (oh_ev) begin
        err_onehot <= 1'b1;
      end
`ifdef TL_MON_TIMEOUT_EN
      if (to_ev) begin
        err_timeout <= 1'b1;
      end
`endif
      if (any_ev && (err_cnt != 8'hff)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive observer on the R/G/Y lamp outputs of the traffic light controller. It measures how long each lamp phase lasts and reports each completed phase with a one-cycle valid pulse. It also checks the lamp sequence: one lamp at a time, in the order G→Y→R→G, and it counts violations. It sits beside the controller in the top level and on the verification bench, and drives nothing back into the controller.

## Interface
Parameters:
- CNT_W, 16, width of the phase-length counter and of phase_len
- MAX_PHASE, 16'd1000, phase-length limit; only used with TL_MON_TIMEOUT_EN

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- R  input  1  red lamp from the controller
- G  input  1  green lamp from the controller
- Y  input  1  yellow lamp from the controller
- phase_vld  output  1  one-cycle pulse; a phase just ended
- phase_id  output  2  ended phase: 1=G, 2=Y, 3=R
- phase_len  output  CNT_W  number of cycles the ended phase was held
- err_seq  output  1  sticky; an illegal transition between valid phases occurred
- err_onehot  output  1  sticky; two or more lamps were seen on in the same cycle
- err_cnt  output  8  saturating count of error events
- err_timeout  output  1  sticky; a phase exceeded MAX_PHASE (present only with TL_MON_TIMEOUT_EN)

## Operation
- Sample stage: {R,G,Y} is registered into smp every cycle; smp_d holds the previous smp.
- Phase decode of smp:
  - G only = 1, Y only = 2, R only = 3.
  - All off, or two or more lamps on = NONE (0).
- State: cur (2b, current phase) and cnt (CNT_W, cycles in the current phase).
- Each cycle, with new = decode(smp):
  - new == cur: cnt <= cnt+1, saturating at all-ones.
  - new != cur:
    - cur <= new, cnt <= 1.
    - If cur != NONE: phase_vld <= 1, phase_id <= cur, phase_len <= cnt.
- Legal transitions: G→Y, Y→R, R→G.
  - Any valid→valid transition other than these is an error event. It sets err_seq.
  - A transition from NONE to any phase is a resync and is not an error.
  - A transition from a valid phase to all-off emits phase_vld and is not an error.
- Multi-hot event: smp has 2 or more bits set and smp != smp_d. It sets err_onehot.
  - A multi-hot pattern that holds steady counts as one event.
- err_cnt increments by 1 per cycle that contains at least one error event, saturating at 255.
- phase_vld is low in every cycle except the emit cycle. phase_id and phase_len hold their value until the next emit.

## Timing
- Reset values:
  - smp, smp_d = 3'b000; cur = NONE; cnt = 0.
  - phase_vld = 0, phase_id = 0, phase_len = 0.
  - err_seq = 0, err_onehot = 0, err_cnt = 0, err_timeout = 0.
- Latency: a lamp change on the inputs before edge n is captured into smp at edge n. phase_vld is high in the cycle following edge n+1, i.e. 2 cycles after the input change.
- phase_len equals the exact number of cycles the old lamp pattern was presented at the inputs, unless it saturated.
- Back-to-back phase changes on consecutive cycles give consecutive phase_vld pulses, each with phase_len = 1.
- The first phase after reset, or after a NONE period, produces no pulse when it starts. It produces a pulse when it ends.
- Reset mid-phase: the partial phase is discarded without a pulse; sticky flags and err_cnt are cleared.
- Error flags and err_cnt update in the same edge as the cur update, i.e. 2 cycles after the offending input.

## Configuration
- TL_MON_TIMEOUT_EN defined:
  - err_timeout port exists.
  - When cur != NONE and cnt transitions to MAX_PHASE, err_timeout is set (sticky).
  - The same event also increments err_cnt, once per phase.
- TL_MON_TIMEOUT_EN undefined: no err_timeout port, no comparator, and MAX_PHASE is ignored.

## Test plan
- Reset, then G for 10 cycles, Y 3, R 8, G 5 → pulses (1,10), (2,3), (3,8). No pulse for the first G. All err flags are 0.
- G 4 then R 4 (skips Y) → pulse (1,4), err_seq=1, err_cnt=1. A following R→G raises no further error.
- G 4, then {R,G}=11 for 3 cycles, then Y → pulse (1,4), err_onehot=1, err_cnt=1. No pulse for the NONE period. No err_seq on NONE→Y.
- Alternate G/Y/R every cycle for 6 cycles → 5 consecutive pulses, each with phase_len=1. Any illegal step in the sequence increments err_cnt.
- Assert rst for 1 cycle at cycle 7 of a G phase with err_seq=1 → all outputs return to reset values at the next edge. The next phase's pulse counts from after reset.
- With TL_MON_TIMEOUT_EN and MAX_PHASE=20, hold R for 30 cycles → err_timeout rises 21 cycles after R appears at the inputs, err_cnt=1, and on exit the pulse is (3,30).
